mem_stage: RTL and testbench

//  Pipeline MEM stage between the EX/MEM and MEM/WB registers of the 64-bit RV64I core.

---
 rtl/mem_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage of the 64-bit RV64I core.
//
// Sits between the EX/MEM and MEM/WB registers. ALU ops pass straight
// through in one cycle. Loads and stores run a req/ack transaction on the
// data-memory port while stall freezes the upstream stages. Store data is
// shifted into byte lanes with matching byte strobes, and load data is
// aligned and then sign- or zero-extended. Misaligned accesses fault without
// touching memory. An access whose ack never arrives is aborted with a bus
// timeout fault.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   ex_*                     EX/MEM register contents (op, rd, result/address, rs2 data)
//   stall                    1 = EX/MEM must hold its op
//   dmem_req/we/addr/wdata/wstrb, dmem_rdata/ack   data-memory request/response port
//   wb_valid/opcode/rd/result/we/fault             MEM/WB register outputs
//
// Timeout accounting: the request is raised in the IDLE cycle that accepts
// the op. Waiting continues for up to TIMEOUT further ACCESS cycles. An ack
// in the last of those cycles still completes normally.
module mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_func3,
  input  logic [4:0]        ex_rd,
  input  logic [63:0]       ex_result,
  input  logic [63:0]       ex_data2,
  input  logic              ex_mem_rw,
  input  logic              ex_is_load,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic [63:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [6:0]        wb_opcode,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_result,
  output logic              wb_we,
  output logic [1:0]        wb_fault
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  // Op captured when a memory access leaves IDLE
  logic [63:0] cap_result_reg;
  logic [63:0] cap_data2_reg;
  logic [6:0]  cap_opcode_reg;
  logic [4:0]  cap_rd_reg;
  logic [2:0]  cap_func3_reg;
  logic        cap_load_reg;

  // MEM/WB register
  logic        wb_valid_reg;
  logic [6:0]  wb_opcode_reg;
  logic [4:0]  wb_rd_reg;
  logic [63:0] wb_result_reg;
  logic        wb_we_reg;
  logic [1:0]  wb_fault_reg;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] fmt_load(input logic [63:0] rdata,
                                           input logic [2:0]  f3,
                                           input logic [2:0]  off);
    logic [63:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{56{lane[7]}},  lane[7:0]};
      3'b001:  return {{48{lane[15]}}, lane[15:0]};
      3'b010:  return {{32{lane[31]}}, lane[31:0]};
      3'b100:  return {56'd0, lane[7:0]};
      3'b101:  return {48'd0, lane[15:0]};
      3'b110:  return {32'd0, lane[31:0]};
      default: return lane;
    endcase
  endfunction

  // Classification of the op currently offered by EX/MEM
  logic       ex_mem;
  logic       ex_misaligned;
  logic       ex_go;
  logic [2:0] ex_off;

  assign ex_off = ex_result[2:0];
  assign ex_mem = ex_is_load | ex_mem_rw;

  always_comb begin
    ex_misaligned = 1'b0;
    case (ex_func3[1:0])
      2'd1:    ex_misaligned = ex_off[0];
      2'd2:    ex_misaligned = |ex_off[1:0];
      2'd3:    ex_misaligned = |ex_off;
      default: ex_misaligned = 1'b0;
    endcase
    if (ex_func3 == 3'b111) ex_misaligned = 1'b1;
  end

  // Combinational outputs are gated with rst so everything reads 0 during reset
  assign ex_go = rst & ex_valid & ex_mem & ~ex_misaligned;

  // In IDLE the access is issued straight from the EX/MEM fields. Later
  // cycles use the captured copy, which keeps dmem_* stable.
  logic        in_idle;
  logic [63:0] cur_result;
  logic [63:0] cur_data2;
  logic [6:0]  cur_opcode;
  logic [4:0]  cur_rd;
  logic [2:0]  cur_func3;
  logic        cur_load;

  assign in_idle    = (state_reg == IDLE);
  assign cur_result = in_idle ? ex_result  : cap_result_reg;
  assign cur_data2  = in_idle ? ex_data2   : cap_data2_reg;
  assign cur_opcode = in_idle ? ex_opcode  : cap_opcode_reg;
  assign cur_rd     = in_idle ? ex_rd      : cap_rd_reg;
  assign cur_func3  = in_idle ? ex_func3   : cap_func3_reg;
  assign cur_load   = in_idle ? ex_is_load : cap_load_reg;

  logic timeout_hit;
  logic [63:0] done_result;
  logic        done_we;

  assign stall    = (in_idle & ex_go) | (rst & (state_reg == ACCESS));
  assign dmem_req = stall;
  assign dmem_we  = dmem_req & ~cur_load;
  assign dmem_addr  = dmem_req ? {cur_result[ADDR_W-1:3], 3'b000} : '0;
  assign dmem_wstrb = dmem_we ? (size_mask(cur_func3[1:0]) << cur_result[2:0]) : 8'h00;
  assign dmem_wdata = dmem_we ? (cur_data2 << {cur_result[2:0], 3'b000}) : 64'd0;

  assign timeout_hit = (state_reg == ACCESS) & ~dmem_ack & (cnt_reg == CNT_W'(TIMEOUT - 1));
  assign done_result = cur_load ? fmt_load(dmem_rdata, cur_func3, cur_result[2:0]) : cur_result;
  assign done_we     = cur_load & (cur_rd != 5'd0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ex_go) state_next = dmem_ack ? RESP : ACCESS;
      ACCESS:  if (dmem_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      cap_result_reg <= '0;
      cap_data2_reg  <= '0;
      cap_opcode_reg <= '0;
      cap_rd_reg     <= '0;
      cap_func3_reg  <= '0;
      cap_load_reg   <= 1'b0;
      wb_valid_reg   <= 1'b0;
      wb_opcode_reg  <= '0;
      wb_rd_reg      <= '0;
      wb_result_reg  <= '0;
      wb_we_reg      <= 1'b0;
      wb_fault_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (ex_go) begin
            cap_result_reg <= ex_result;
            cap_data2_reg  <= ex_data2;
            cap_opcode_reg <= ex_opcode;
            cap_rd_reg     <= ex_rd;
            cap_func3_reg  <= ex_func3;
            cap_load_reg   <= ex_is_load;
          end
          if (!ex_valid) begin
            wb_valid_reg <= 1'b0;
            wb_we_reg    <= 1'b0;
            wb_fault_reg <= 2'b00;
          end else if (!ex_mem) begin
            wb_valid_reg  <= 1'b1;
            wb_opcode_reg <= ex_opcode;
            wb_rd_reg     <= ex_rd;
            wb_result_reg <= ex_result;
            wb_we_reg     <= (ex_rd != 5'd0);
            wb_fault_reg  <= 2'b00;
          end else if (ex_misaligned) begin
            wb_valid_reg  <= 1'b1;
            wb_opcode_reg <= ex_opcode;
            wb_rd_reg     <= ex_rd;
            wb_result_reg <= ex_result;
            wb_we_reg     <= 1'b0;
            wb_fault_reg  <= 2'b01;
          end else if (dmem_ack) begin
            // ack in the very first request cycle: skip ACCESS
            wb_valid_reg  <= 1'b1;
            wb_opcode_reg <= cur_opcode;
            wb_rd_reg     <= cur_rd;
            wb_result_reg <= done_result;
            wb_we_reg     <= done_we;
            wb_fault_reg  <= 2'b00;
          end else begin
            wb_valid_reg <= 1'b0;
            wb_we_reg    <= 1'b0;
            wb_fault_reg <= 2'b00;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (dmem_ack) begin
            wb_valid_reg  <= 1'b1;
            wb_opcode_reg <= cur_opcode;
            wb_rd_reg     <= cur_rd;
            wb_result_reg <= done_result;
            wb_we_reg     <= done_we;
            wb_fault_reg  <= 2'b00;
          end else if (timeout_hit) begin
            wb_valid_reg  <= 1'b1;
            wb_opcode_reg <= cur_opcode;
            wb_rd_reg     <= cur_rd;
            wb_result_reg <= cur_result;
            wb_we_reg     <= 1'b0;
            wb_fault_reg  <= 2'b10;
          end
        end
        default: begin
          // RESP: MEM/WB was loaded on entry; it holds valid for this one cycle only
          wb_valid_reg <= 1'b0;
          wb_we_reg    <= 1'b0;
          wb_fault_reg <= 2'b00;
        end
      endcase
    end
  end

  assign wb_valid  = wb_valid_reg;
  assign wb_opcode = wb_opcode_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_result = wb_result_reg;
  assign wb_we     = wb_we_reg;
  assign wb_fault  = wb_fault_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- randomized self-checking bench for mem_stage.
// Expected values come from a behavioural model that works from byte
// offsets, access sizes and plain arithmetic.
module tb_mem_stage;
  localparam int AW = 32;
  localparam int TO = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [6:0]    ex_opcode;
  logic [2:0]    ex_func3;
  logic [4:0]    ex_rd;
  logic [63:0]   ex_result;
  logic [63:0]   ex_data2;
  logic          ex_mem_rw;
  logic          ex_is_load;
  logic          stall;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [63:0]   dmem_wdata;
  logic [7:0]    dmem_wstrb;
  logic [63:0]   dmem_rdata;
  logic          dmem_ack;
  logic          wb_valid;
  logic [6:0]    wb_opcode;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_result;
  logic          wb_we;
  logic [1:0]    wb_fault;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_data2(ex_data2), .ex_mem_rw(ex_mem_rw), .ex_is_load(ex_is_load),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_rd(wb_rd), .wb_result(wb_result),
    .wb_we(wb_we), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [63:0] a);
    int off;
    off = int'(a[2:0]);
    if (f3 == 3'b111) return 1'b1;
    return (off % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] a);
    logic [15:0] m;
    m = ((16'd1 << acc_bytes(f3)) - 16'd1) << int'(a[2:0]);
    return m[7:0];
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] d2, input logic [63:0] a);
    return d2 << (8 * int'(a[2:0]));
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] f3,
                                           input logic [63:0] a);
    int bits;
    logic [63:0] v, mask;
    bits = 8 * acc_bytes(f3);
    v = rd >> (8 * int'(a[2:0]));
    if (bits < 64) begin
      mask = (64'd1 << bits) - 64'd1;
      v = v & mask;
      if (f3 < 3'd4 && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- transaction drivers ----------------
  task automatic do_alu(input logic [6:0] opc, input logic [4:0] rd, input logic [63:0] res);
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = opc; ex_func3 = 3'($urandom); ex_rd = rd;
    ex_result = res; ex_data2 = {$urandom, $urandom}; ex_mem_rw = 1'b0; ex_is_load = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_no_req: stall=%b req=%b, required 0 0", stall, dmem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_we !== (rd != 5'd0) || wb_fault !== 2'b00 ||
        wb_result !== res || wb_rd !== rd || wb_opcode !== opc) begin
      errors++;
      $display("FAIL alu_wb: v=%b we=%b f=%b res=%h rd=%0d op=%h, required 1 %b 00 %h %0d %h",
               wb_valid, wb_we, wb_fault, wb_result, wb_rd, wb_opcode, rd != 5'd0, res, rd, opc);
    end
    $display("alu    op=%h rd=%0d res=%h", opc, rd, res);
  endtask

  // ack_dly: cycle (0 = first request cycle) on which dmem_ack pulses; > TO means never
  task automatic do_mem(input bit store, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] d2, input logic [63:0] rdata, input logic [4:0] rd,
                        input int ack_dly);
    logic [6:0]    opc;
    logic [AW-1:0] eaddr;
    logic [63:0]   exp_res;
    logic [1:0]    exp_fault;
    logic          exp_we;
    bit            mis, got_ack;
    opc = store ? 7'h23 : 7'h03;
    mis = ref_misaligned(f3, a);
    eaddr = a[AW-1:0];
    eaddr[2:0] = 3'b000;
    got_ack = 1'b0;
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = opc; ex_func3 = f3; ex_rd = rd; ex_result = a;
    ex_data2 = d2; ex_mem_rw = store; ex_is_load = !store;
    if (mis) begin
      dmem_ack = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_no_req: stall=%b req=%b, required 0 0", stall, dmem_req);
      end
      @(posedge clk); #1;
      exp_res = a; exp_fault = 2'b01; exp_we = 1'b0;
    end else begin
      for (int k = 0; k <= TO; k++) begin
        if (k > 0) @(negedge clk);
        dmem_ack   = (k == ack_dly);
        dmem_rdata = (k == ack_dly) ? rdata : {$urandom, $urandom};
        #1;
        checks++;
        if (dmem_req !== 1'b1 || stall !== 1'b1 || dmem_we !== store || dmem_addr !== eaddr) begin
          errors++;
          $display("FAIL mem_req c%0d: req=%b stall=%b we=%b addr=%h, required 1 1 %b %h",
                   k, dmem_req, stall, dmem_we, dmem_addr, store, eaddr);
        end
        if (store) begin
          checks++;
          if (dmem_wstrb !== ref_strb(f3, a) || dmem_wdata !== ref_wdata(d2, a)) begin
            errors++;
            $display("FAIL store_lanes c%0d: wstrb=%h wdata=%h, required %h %h",
                     k, dmem_wstrb, dmem_wdata, ref_strb(f3, a), ref_wdata(d2, a));
          end
        end
        @(posedge clk);
        if (k == ack_dly) begin
          got_ack = 1'b1;
          break;
        end
      end
      #1;
      if (!got_ack) begin
        exp_res = a; exp_fault = 2'b10; exp_we = 1'b0;
      end else if (store) begin
        exp_res = a; exp_fault = 2'b00; exp_we = 1'b0;
      end else begin
        exp_res = ref_load(rdata, f3, a); exp_fault = 2'b00; exp_we = (rd != 5'd0);
      end
      checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL resp_release: stall=%b req=%b, required 0 0", stall, dmem_req);
      end
    end
    checks++;
    if (wb_valid !== 1'b1 || wb_fault !== exp_fault || wb_we !== exp_we ||
        wb_result !== exp_res || wb_rd !== rd || wb_opcode !== opc) begin
      errors++;
      $display("FAIL mem_wb: v=%b f=%b we=%b res=%h rd=%0d op=%h, required 1 %b %b %h %0d %h",
               wb_valid, wb_fault, wb_we, wb_result, wb_rd, wb_opcode,
               exp_fault, exp_we, exp_res, rd, opc);
    end
    if (!mis) begin
      // EX/MEM advances at the end of RESP; a stray ack now must be ignored
      @(negedge clk);
      dmem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checks++;
      if (wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL wb_one_cycle: wb_valid=%b, required 0", wb_valid);
      end
    end
    $display("%s f3=%0d a=%h ack=%0d fault=%b res=%h", store ? "store " : "load  ",
             f3, a, ack_dly, exp_fault, exp_res);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; ex_valid = 1'b1; ex_opcode = 7'h03; ex_func3 = 3'b011; ex_rd = 5'd1;
    ex_result = 64'h100; ex_data2 = 64'd0; ex_mem_rw = 1'b0; ex_is_load = 1'b1;
    dmem_rdata = 64'd0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, dmem_req, dmem_we, wb_valid, wb_we} !== 5'b0 || dmem_addr !== '0 ||
        dmem_wdata !== 64'd0 || dmem_wstrb !== 8'd0 || wb_opcode !== 7'd0 || wb_rd !== 5'd0 ||
        wb_result !== 64'd0 || wb_fault !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b wbv=%b res=%h, required all 0",
               stall, dmem_req, wb_valid, wb_result);
    end
    @(negedge clk);
    rst = 1'b1; ex_valid = 1'b0;
    $display("reset  done");
  endtask

  task automatic test_idle();
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = 1'b1; ex_result = {$urandom, $urandom};
    dmem_ack = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: stall=%b req=%b, required 0 0", stall, dmem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_wb: wb_valid=%b wb_we=%b, required 0 0", wb_valid, wb_we);
    end
    dmem_ack = 1'b0;
    $display("idle   ex_valid=0");
  endtask

  task automatic test_alu();
    do_alu(7'h13, 5'd5, 64'h1234);
    do_alu(7'h33, 5'd0, {$urandom, $urandom});
    for (int i = 0; i < 4; i++)
      do_alu(7'h33, 5'($urandom_range(1, 31)), {$urandom, $urandom});
  endtask

  task automatic test_directed();
    do_mem(1'b0, 3'b000, 64'h13, 64'd0, 64'h00000000_80FF0000, 5'd7, 1);   // LB sign-extend
    do_mem(1'b1, 3'b001, 64'h06, 64'hABCD, 64'd0, 5'd3, 2);                 // SH upper lanes
    do_mem(1'b0, 3'b010, 64'h02, 64'd0, 64'd0, 5'd4, 0);                    // LW misaligned
    do_mem(1'b0, 3'b011, 64'h40, 64'd0, 64'd0, 5'd9, TO + 1);               // LD timeout
    do_mem(1'b0, 3'b011, 64'h48, 64'd0, 64'hDEAD_BEEF_0123_4567, 5'd9, TO); // ack on last cycle
    do_mem(1'b0, 3'b100, 64'h0F, 64'd0, 64'hF100_0000_0000_0000, 5'd2, 0);  // LBU, same-cycle ack
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = 7'h03; ex_func3 = 3'b011; ex_rd = 5'd8;
    ex_result = 64'h80; ex_mem_rw = 1'b0; ex_is_load = 1'b1; dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_req: req=%b stall=%b, required 1 1", dmem_req, stall);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ex_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0 || wb_we !== 1'b0 ||
        dmem_addr !== '0 || wb_result !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: req=%b stall=%b wbv=%b addr=%h, required 0 0 0 0",
               dmem_req, stall, wb_valid, dmem_addr);
    end
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = {$urandom, $urandom};
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_req: req=%b stall=%b, required 0 0", dmem_req, stall);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_ignored: wb_valid=%b wb_we=%b, required 0 0", wb_valid, wb_we);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    $display("reset  mid-access, late ack dropped");
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3;
    logic [63:0] a;
    bit          st;
    int          r, dly;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        do_alu(7'h13, 5'($urandom_range(0, 31)), {$urandom, $urandom});
      end else begin
        st = 1'($urandom_range(0, 1));
        f3 = st ? ((r == 9) ? 3'b111 : 3'($urandom_range(0, 3))) : 3'($urandom_range(0, 7));
        a = {$urandom, $urandom};
        if ($urandom_range(0, 4) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
        r = $urandom_range(0, 9);
        dly = (r < 8) ? (r % 4) : ((r == 8) ? TO : TO + 1);
        do_mem(st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
               5'($urandom_range(0, 31)), dly);
      end
      if ($urandom_range(0, 7) == 0) test_idle();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_alu();
    test_directed();
    test_reset_mid_access();
    test_back_to_back();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
